// File: rtl/tick_sched_pkg.sv
// Shared types and parameters for the tick scheduler: channel state encoding,
// default widths and the channel-index width helper.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } chan_state_t;

  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W_DEF  = 28;

  // Smallest index width able to address n channels (at least one bit).
  function automatic int ch_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One scheduler channel: OFF/RUN/PEND FSM, period down-counter, shadow period
// register and the registered one-cycle tick.
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             active_o,
  output logic             pend_o,
  output logic             pend_next_o
);

  chan_state_t      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0] shad_q, shad_d;
  logic [DIV_W-1:0] load_div, cnt_eff;
  logic             tick_q, tick_d;
  logic             load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      cur_q   <= '0;
      shad_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      shad_q  <= shad_d;
      tick_q  <= tick_d;
    end
  end

  // A load restarts the period so that the current cycle is its first counted cycle.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    shad_d   = shad_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    load     = 1'b0;
    load_div = cur_q;
    cnt_eff  = cnt_q;
    if (wr_i && ((state_q == OFF) || sync_i)) begin
      if (wr_div_i != '0) begin
        state_d  = RUN;
        cur_d    = wr_div_i;
        load     = 1'b1;
        load_div = wr_div_i;
      end else begin
        state_d = OFF;
      end
    end else if (wr_i && (wr_div_i == '0)) begin
      state_d = OFF;
    end else if (sync_i && (state_q != OFF)) begin
      state_d  = RUN;
      load     = 1'b1;
      load_div = (state_q == PEND) ? shad_q : cur_q;
      cur_d    = load_div;
    end else if (wr_i) begin
      state_d = PEND;
      shad_d  = wr_div_i;
    end else begin
      state_d = state_q;
    end

    if (state_d == OFF) begin
      cnt_d = '0;
    end else if (!run_i) begin
      cnt_d = load ? (load_div - DIV_W'(1)) : cnt_q;
    end else begin
      cnt_eff = load ? (load_div - DIV_W'(1)) : cnt_q;
      if (cnt_eff == '0) begin
        tick_d = 1'b1;
        if (!load && (state_q == PEND)) begin
          state_d = RUN;
          cur_d   = shad_q;
          cnt_d   = shad_q - DIV_W'(1);
        end else begin
          cnt_d = cur_d - DIV_W'(1);
        end
      end else begin
        cnt_d = cnt_eff - DIV_W'(1);
      end
    end
  end

  always_comb begin
    tick_o      = tick_q;
    active_o    = (state_q != OFF);
    pend_o      = (state_q == PEND);
    pend_next_o = (state_d == PEND);
  end

endmodule

// File: rtl/tick_sched.sv
// Clock-enable scheduler: decodes config writes onto NUM_CH tick channels,
// fans out sync and holds cfg_ready low while any channel has a pending period.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] active_o
);

  logic [NUM_CH-1:0] wr_s;
  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] pend_next_s;
  logic              ready_q, ready_d;

  always_comb begin
    wr_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_s[c] = cfg_valid_i && ready_q && (cfg_ch_i == CH_W'(c));
    end
  end

  // Ready drops as soon as a write enters PEND and recovers one cycle after it resolves.
  always_comb begin
    ready_d = ~((|pend_s) | (|pend_next_s));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign cfg_ready_o = ready_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    tick_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .run_i      (run_i),
      .sync_i     (sync_i),
      .wr_i       (wr_s[c]),
      .wr_div_i   (cfg_div_i),
      .tick_o     (tick_o[c]),
      .active_o   (active_o[c]),
      .pend_o     (pend_s[c]),
      .pend_next_o(pend_next_s[c])
    );
  end

endmodule
